// File: rtl/dpkd_pkg.sv
// Shared types, constants and helpers for the DPLL phase divider.
package dpkd_pkg;

   localparam int unsigned MIN_DIV = 2;

   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_ADV  = 2'd1,
      REQ_RET  = 2'd2
   } req_e;

   // Signed saturation of a corrected period into [lo, hi].
   function automatic int clamp_int(input int value, input int lo, input int hi);
      if (value < lo) return lo;
      if (value > hi) return hi;
      return value;
   endfunction

endpackage

// File: rtl/dpkd_phase_divider_if.sv
// Control/status bundle of the phase divider; master drives controls, slave is the divider.
interface dpkd_phase_divider_if #(
   parameter int unsigned CNT_W = 8
);

   logic             en_i;
   logic [CNT_W-1:0] div_ratio_i;
   logic             div_load_i;
   logic             positiveShift_i;
   logic             negativeShift_i;
   logic             output_o;
   logic             tick_o;
   logic [CNT_W-1:0] phase_o;
   logic             shift_ovf_o;

   modport master (
      output en_i, div_ratio_i, div_load_i, positiveShift_i, negativeShift_i,
      input  output_o, tick_o, phase_o, shift_ovf_o
   );

   modport slave (
      input  en_i, div_ratio_i, div_load_i, positiveShift_i, negativeShift_i,
      output output_o, tick_o, phase_o, shift_ovf_o
   );

endinterface

// File: rtl/dpkd_shift_acc.sv
// Pending phase-shift accumulator: encodes advance/retard requests and saturates at +/-SHIFT_MAX.
// Build with DPKD_SHIFT_EDGE_EN to count only rising edges of the request inputs.
module dpkd_shift_acc
   import dpkd_pkg::*;
#(
   parameter int unsigned SHIFT_MAX = 8,
   parameter int unsigned ACC_W     = $clog2(SHIFT_MAX) + 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    advance,
   input  logic                    retard,
   input  logic                    wrap,
   output logic signed [ACC_W-1:0] acc,
   output logic                    ovf
);

   localparam logic signed [ACC_W:0] LIM = $signed((ACC_W+1)'(SHIFT_MAX));

   logic                  adv_c;
   logic                  ret_c;
   req_e                  req_c;
   logic signed [ACC_W:0] req_val_c;
   logic signed [ACC_W:0] sum_c;
   logic                  sat_c;

`ifdef DPKD_SHIFT_EDGE_EN
   logic adv_q;
   logic ret_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         adv_q <= 1'b0;
         ret_q <= 1'b0;
      end else begin
         adv_q <= advance;
         ret_q <= retard;
      end
   end

   assign adv_c = advance & ~adv_q;
   assign ret_c = retard & ~ret_q;
`else
   assign adv_c = advance;
   assign ret_c = retard;
`endif

   // Opposing requests in the same cycle cancel out.
   always_comb begin
      req_c     = REQ_NONE;
      req_val_c = '0;
      if (adv_c && !ret_c)      req_c = REQ_ADV;
      else if (ret_c && !adv_c) req_c = REQ_RET;
      case (req_c)
         REQ_ADV: req_val_c = (ACC_W+1)'(1);
         REQ_RET: req_val_c = '1;
         default: req_val_c = '0;
      endcase
      sum_c = $signed({acc[ACC_W-1], acc}) + req_val_c;
      sat_c = (sum_c > LIM) || (sum_c < -LIM);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (wrap) begin
         acc <= req_val_c[ACC_W-1:0];
         ovf <= 1'b0;
      end else if (sat_c) begin
         ovf <= 1'b1;
      end else begin
         acc <= sum_c[ACC_W-1:0];
         ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/dpkd_phase_divider.sv
// Variable-ratio DPLL divider: square wave, period tick and phase count with per-period shift correction.
// Optional DPKD_SHIFT_EDGE_EN makes shift requests edge-triggered (see dpkd_shift_acc).
module dpkd_phase_divider
   import dpkd_pkg::*;
#(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned DIV_DEFAULT = 200,
   parameter int unsigned SHIFT_MAX   = 8
) (
   input logic                clk_i,
   input logic                reset_i,
   dpkd_phase_divider_if.slave bus
);

   localparam int unsigned   ACC_W     = $clog2(SHIFT_MAX) + 2;
   localparam int            MAX_DIV   = (2 ** CNT_W) - 1;
   localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DIV_DEFAULT);
   localparam logic [CNT_W-1:0] MIN_DIV_W = CNT_W'(MIN_DIV);

   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        period_len;
   logic [CNT_W-1:0]        active_div;
   logic [CNT_W-1:0]        pending_div;
   logic                    load_pend;
   logic                    out_q;
   logic                    tick_q;
   logic signed [ACC_W-1:0] acc;
   logic                    shift_ovf;

   logic                    wrap_c;
   logic [CNT_W-1:0]        base_c;
   logic [CNT_W-1:0]        load_val_c;
   logic [CNT_W-1:0]        cnt_inc_c;
   logic [CNT_W-1:0]        next_len_c;
   logic signed [CNT_W+1:0] corr_c;

   dpkd_shift_acc #(
      .SHIFT_MAX (SHIFT_MAX),
      .ACC_W     (ACC_W)
   ) u_shift_acc (
      .clk     (clk_i),
      .reset   (reset_i),
      .advance (bus.positiveShift_i),
      .retard  (bus.negativeShift_i),
      .wrap    (wrap_c),
      .acc     (acc),
      .ovf     (shift_ovf)
   );

   // Next period length: base ratio minus pending shift, clamped; residue is dropped.
   always_comb begin
      wrap_c     = bus.en_i && (cnt == period_len - CNT_W'(1));
      base_c     = load_pend ? pending_div : active_div;
      corr_c     = $signed({2'b00, base_c}) -
                   $signed({{(CNT_W+2-ACC_W){acc[ACC_W-1]}}, acc});
      next_len_c = CNT_W'(clamp_int(int'(corr_c), int'(MIN_DIV), MAX_DIV));
      load_val_c = (bus.div_ratio_i < MIN_DIV_W) ? MIN_DIV_W : bus.div_ratio_i;
      cnt_inc_c  = cnt + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt         <= '0;
         period_len  <= DIV_RST;
         active_div  <= DIV_RST;
         pending_div <= DIV_RST;
         load_pend   <= 1'b0;
         out_q       <= 1'b1;
         tick_q      <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         if (wrap_c) begin
            active_div <= base_c;
            period_len <= next_len_c;
            load_pend  <= 1'b0;
            cnt        <= '0;
            out_q      <= 1'b1;
            tick_q     <= 1'b1;
         end else if (bus.en_i) begin
            cnt   <= cnt_inc_c;
            out_q <= (cnt_inc_c < (period_len >> 1));
         end
         // A load in the wrap cycle survives the clear above and applies at the next wrap.
         if (bus.div_load_i) begin
            pending_div <= load_val_c;
            load_pend   <= 1'b1;
         end
      end
   end

   assign bus.output_o    = out_q;
   assign bus.tick_o      = tick_q;
   assign bus.phase_o     = cnt;
   assign bus.shift_ovf_o = shift_ovf;

endmodule

// File: tb/tb_dpkd_phase_divider.sv
// Directed bench for dpkd_phase_divider (CNT_W=8, DIV_DEFAULT=8, SHIFT_MAX=4).
module tb_dpkd_phase_divider;

`ifdef DPKD_SHIFT_EDGE_EN
   localparam int NEG3_LEN = 9, NEG3_HIGH = 4;
   localparam int POS6_OVF = 0, POS6_FIRST = -1, POS6_LEN = 7, POS6_HIGH = 3;
   localparam int P3_LEN = 7, P3_HIGH = 3, EN_LEN = 7, EN_HIGH = 3;
`else
   localparam int NEG3_LEN = 11, NEG3_HIGH = 5;
   localparam int POS6_OVF = 2, POS6_FIRST = 6, POS6_LEN = 4, POS6_HIGH = 2;
   localparam int P3_LEN = 5, P3_HIGH = 2, EN_LEN = 6, EN_HIGH = 3;
`endif

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   last_first_ovf;
   int   n;

   dpkd_phase_divider_if #(.CNT_W(8)) bus ();

   dpkd_phase_divider #(
      .CNT_W       (8),
      .DIV_DEFAULT (8),
      .SHIFT_MAX   (4)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one period starting at a tick sample; stops at the next tick sample.
   task automatic run_period(input int af, input int an, input int rf, input int rn,
                             input int la, input int lv,
                             output int len, output int high, output int ovfs);
      bit done;
      done = 1'b0;
      len = 0; high = 0; ovfs = 0; last_first_ovf = -1;
      for (int g = 0; g < 300 && !done; g++) begin
         if (bus.shift_ovf_o) begin
            ovfs++;
            if (last_first_ovf < 0) last_first_ovf = len;
         end
         if (bus.output_o) high++;
         bus.positiveShift_i = (len >= af) && (len < af + an);
         bus.negativeShift_i = (len >= rf) && (len < rf + rn);
         bus.div_load_i      = (len == la);
         bus.div_ratio_i     = 8'(lv);
         step();
         len++;
         if (bus.tick_o) done = 1'b1;
      end
      bus.positiveShift_i = 1'b0;
      bus.negativeShift_i = 1'b0;
      bus.div_load_i      = 1'b0;
      if (!done) len = -1;
   endtask

   task automatic ex(input string tag, input int af, input int an, input int rf, input int rn,
                     input int la, input int lv, input int e_len, input int e_high, input int e_ovf);
      int len, high, ovfs;
      run_period(af, an, rf, rn, la, lv, len, high, ovfs);
      check({tag, "_len"}, 32'(len), 32'(e_len));
      check({tag, "_high"}, 32'(high), 32'(e_high));
      check({tag, "_ovf"}, 32'(ovfs), 32'(e_ovf));
   endtask

   // Steps until the next tick; returns the number of edges or -1 on timeout.
   task automatic edges_to_tick(output int cnt_out);
      bit done;
      done = 1'b0;
      cnt_out = 0;
      for (int g = 0; g < 300 && !done; g++) begin
         step();
         cnt_out++;
         if (bus.tick_o) done = 1'b1;
      end
      if (!done) cnt_out = -1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.en_i            = 1'b1;
      bus.div_ratio_i     = '0;
      bus.div_load_i      = 1'b0;
      bus.positiveShift_i = 1'b0;
      bus.negativeShift_i = 1'b0;
      step();
      step();
      check("rst_out", 32'(bus.output_o), 32'd1);
      check("rst_tick", 32'(bus.tick_o), 32'd0);
      check("rst_phase", 32'(bus.phase_o), 32'd0);
      check("rst_ovf", 32'(bus.shift_ovf_o), 32'd0);
      rst = 1'b0;

      // First period after reset, cycle by cycle.
      for (int i = 1; i < 8; i++) begin
         step();
         check("p0_phase", 32'(bus.phase_o), 32'(i));
         check("p0_out", 32'(bus.output_o), (i < 4) ? 32'd1 : 32'd0);
      end
      step();
      check("p0_tick", 32'(bus.tick_o), 32'd1);
      check("p0_wrap_phase", 32'(bus.phase_o), 32'd0);
      check("p0_wrap_out", 32'(bus.output_o), 32'd1);

      ex("base",       -1, 0, -1, 0, -1, 0, 8, 4, 0);
      ex("adv1_cur",    3, 1, -1, 0, -1, 0, 8, 4, 0);
      ex("adv1_next",  -1, 0, -1, 0, -1, 0, 7, 3, 0);
      ex("adv1_back",  -1, 0, -1, 0, -1, 0, 8, 4, 0);

      ex("ret3_cur",   -1, 0,  2, 3, -1, 0, 8, 4, 0);
      ex("both_cur",    2, 3,  2, 3, -1, 0, NEG3_LEN, NEG3_HIGH, 0);
      ex("both_next",  -1, 0, -1, 0, -1, 0, 8, 4, 0);

      ex("pos6_cur",    1, 6, -1, 0, -1, 0, 8, 4, POS6_OVF);
      check("pos6_first_ovf", 32'(last_first_ovf), 32'(POS6_FIRST));
      ex("pos6_next",  -1, 0, -1, 0, -1, 0, POS6_LEN, POS6_HIGH, 0);
      ex("pos6_back",  -1, 0, -1, 0, -1, 0, 8, 4, 0);

      ex("pos3_cur",    2, 3, -1, 0, -1, 0, 8, 4, 0);
      ex("pos3_next",  -1, 0, -1, 0, -1, 0, P3_LEN, P3_HIGH, 0);

      ex("load3_cur",  -1, 0, -1, 0,  2, 3, 8, 4, 0);
      ex("load3_a",    -1, 0, -1, 0, -1, 0, 3, 1, 0);
      ex("load3_b",    -1, 0, -1, 0, -1, 0, 3, 1, 0);
      ex("load0_cur",  -1, 0, -1, 0,  1, 0, 3, 1, 0);
      ex("load0_a",    -1, 0, -1, 0, -1, 0, 2, 1, 0);
      ex("load0_b",    -1, 0, -1, 0, -1, 0, 2, 1, 0);

      ex("load8_cur",  -1, 0, -1, 0,  0, 8, 2, 1, 0);
      ex("clamp_cur",   1, 4, -1, 0,  1, 3, 8, 4, 0);
      ex("clamp_next", -1, 0, -1, 0, -1, 0, 2, 1, 0);
      ex("clamp_after",-1, 0, -1, 0, -1, 0, 3, 1, 0);
      ex("restore_cur",-1, 0, -1, 0,  0, 8, 3, 1, 0);
      ex("restore",    -1, 0, -1, 0, -1, 0, 8, 4, 0);

      // Reset at cnt=5 with retard requests pending.
      step();
      bus.negativeShift_i = 1'b1;
      step();
      step();
      bus.negativeShift_i = 1'b0;
      step();
      step();
      check("mid_phase", 32'(bus.phase_o), 32'd5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_out", 32'(bus.output_o), 32'd1);
      check("mid_rst_phase", 32'(bus.phase_o), 32'd0);
      check("mid_rst_tick", 32'(bus.tick_o), 32'd0);
      edges_to_tick(n);
      check("mid_rst_first_len", 32'(n), 32'd8);
      ex("mid_rst_next", -1, 0, -1, 0, -1, 0, 8, 4, 0);

      // Enable low for 10 cycles while advance requests keep arriving.
      step();
      step();
      bus.en_i = 1'b0;
      bus.positiveShift_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         if (k == 1) bus.positiveShift_i = 1'b0;
         check("en_lo_phase", 32'(bus.phase_o), 32'd2);
         check("en_lo_out", 32'(bus.output_o), 32'd1);
         check("en_lo_tick", 32'(bus.tick_o), 32'd0);
      end
      bus.en_i = 1'b1;
      edges_to_tick(n);
      check("en_resume_len", 32'(n), 32'd6);
      ex("en_next", -1, 0, -1, 0, -1, 0, EN_LEN, EN_HIGH, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
